mod_147_tx_dme: RTL



---
 rtl/mod_147_tx_dme_pkg.sv | 27 ++
 rtl/mod_147_tx_dme_if.sv | 49 ++++
 rtl/mod_147_std_timer.sv | 50 +++++
 rtl/mod_147_tx_dme.sv | 109 ++++++++++
 4 files changed

// File: rtl/mod_147_tx_dme_pkg.sv
// Shared Clause 147 transmit constants: 5B code points, boolean levels, symbol width and FSM state type.
// The optional BASE_T1S_TX_SYMCNT_EN feature is configured in the interface and top, not here.
package mod_147_tx_dme_pkg;

   localparam int SYM_W = 5;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   // 5B code points used by the PCS transmit state diagram.
   localparam logic [SYM_W-1:0] SILENCE = 5'b01000;
   localparam logic [SYM_W-1:0] SYNC    = 5'b11000;
   localparam logic [SYM_W-1:0] SSD     = 5'b10001;
   localparam logic [SYM_W-1:0] ESD     = 5'b01101;
   localparam logic [SYM_W-1:0] ESDOK   = 5'b00111;
   localparam logic [SYM_W-1:0] ESDERR  = 5'b00100;

   typedef enum logic {
      SILENT = 1'b0,
      ACTIVE = 1'b1
   } tx_state_t;

   function automatic logic is_silence(input logic [SYM_W-1:0] sym);
      return (sym == SILENCE);
   endfunction

endpackage

// File: rtl/mod_147_tx_dme_if.sv
// PCS-to-DME transmit bundle; master is the PCS/PMA side, slave is the DME encoder.
// BASE_T1S_TX_SYMCNT_EN adds the 16-bit transmitted-symbol counter to the bundle.
interface mod_147_tx_dme_if;
   import mod_147_tx_dme_pkg::*;

   logic [SYM_W-1:0] tx_sym;
   logic             tx_disable;
   logic             STD;
   logic             tx_dme;
   logic             tx_active;
`ifdef BASE_T1S_TX_SYMCNT_EN
   logic [15:0]      tx_sym_cnt;

   modport master (
      output tx_sym,
      output tx_disable,
      input  STD,
      input  tx_dme,
      input  tx_active,
      input  tx_sym_cnt
   );

   modport slave (
      input  tx_sym,
      input  tx_disable,
      output STD,
      output tx_dme,
      output tx_active,
      output tx_sym_cnt
   );
`else
   modport master (
      output tx_sym,
      output tx_disable,
      input  STD,
      input  tx_dme,
      input  tx_active
   );

   modport slave (
      input  tx_sym,
      input  tx_disable,
      output STD,
      output tx_dme,
      output tx_active
   );
`endif

endinterface

// File: rtl/mod_147_std_timer.sv
// Free-running symbol timer: phase counter, STD pulse, half-bit index and edge-of-half-bit/wrap strobes.
// The bit index within the symbol is half_bit[3:1].
module mod_147_std_timer #(
   parameter int CLK_PER_HALF_BIT = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       std,
   output logic [3:0] half_bit,
   output logic       hb_last,
   output logic       wrap
);

   localparam int SYM_CLKS = 10 * CLK_PER_HALF_BIT;
   localparam int PH_W     = $clog2(SYM_CLKS);
   localparam int SUB_W    = (CLK_PER_HALF_BIT > 1) ? $clog2(CLK_PER_HALF_BIT) : 1;

   logic [SUB_W-1:0] sub_reg;
   logic [3:0]       hb_reg;
   logic             std_reg;
   logic [PH_W-1:0]  phase;

   // Phase is kept as (half-bit, clk-within-half-bit) so half-bit edges need no divider.
   always_comb begin
      phase   = PH_W'(int'(hb_reg) * CLK_PER_HALF_BIT + int'(sub_reg));
      hb_last = (sub_reg == SUB_W'(CLK_PER_HALF_BIT - 1));
      wrap    = hb_last && (hb_reg == 4'd9);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sub_reg <= '0;
         hb_reg  <= '0;
         std_reg <= 1'b0;
      end else begin
         if (hb_last) begin
            sub_reg <= '0;
            hb_reg  <= wrap ? 4'd0 : hb_reg + 4'd1;
         end else begin
            sub_reg <= sub_reg + SUB_W'(1);
         end
         // Registered one phase early so STD is high while phase == SYM_CLKS-2.
         std_reg <= (phase == PH_W'(SYM_CLKS - 3));
      end
   end

   assign std      = std_reg;
   assign half_bit = hb_reg;

endmodule

// File: rtl/mod_147_tx_dme.sv
// Clause 147 transmit DME stage: loads tx_sym at each symbol wrap, serializes MSB first and DME-encodes it.
// Optional macro BASE_T1S_TX_SYMCNT_EN adds the saturating tx_sym_cnt output.
module mod_147_tx_dme
   import mod_147_tx_dme_pkg::*;
#(
   parameter int CLK_PER_HALF_BIT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   mod_147_tx_dme_if.slave   tx
);

   logic       std;
   logic [3:0] half_bit;
   logic       hb_last;
   logic       wrap;

   mod_147_std_timer #(
      .CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .std      (std),
      .half_bit (half_bit),
      .hb_last  (hb_last),
      .wrap     (wrap)
   );

   tx_state_t        state_reg, state_next;
   logic [SYM_W-1:0] shift_reg, shift_next;
   logic             dme_reg, dme_next;
   logic [2:0]       bit_ptr;
   logic             cur_bit;
   logic             load_active;

   // Pointer is 4 at reset/phase 0 and walks down to 0 across the symbol.
   assign bit_ptr     = 3'(SYM_W - 1) - half_bit[3:1];
   assign cur_bit     = shift_reg[bit_ptr];
   assign load_active = wrap && !is_silence(tx.tx_sym) && !tx.tx_disable;

   always_comb begin
      state_next = state_reg;
      shift_next = shift_reg;
      dme_next   = dme_reg;

      if (wrap) begin
         shift_next = tx.tx_sym;
      end

      unique case (state_reg)
         SILENT: begin
            dme_next = 1'b0;
            if (load_active) begin
               state_next = ACTIVE;
               dme_next   = 1'b1;
            end
         end
         ACTIVE: begin
            if (tx.tx_disable || (wrap && is_silence(tx.tx_sym))) begin
               state_next = SILENT;
               dme_next   = 1'b0;
            end else if (hb_last) begin
               // Even current half-bit means the next half-bit is the mid-bit of the same bit.
               if (wrap || half_bit[0]) begin
                  dme_next = ~dme_reg;
               end else if (cur_bit) begin
                  dme_next = ~dme_reg;
               end
            end
         end
         default: begin
            state_next = SILENT;
            dme_next   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= SILENT;
         shift_reg <= SILENCE;
         dme_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         shift_reg <= shift_next;
         dme_reg   <= dme_next;
      end
   end

   assign tx.STD       = std;
   assign tx.tx_dme    = dme_reg;
   assign tx.tx_active = (state_reg == ACTIVE);

`ifdef BASE_T1S_TX_SYMCNT_EN
   logic [15:0] cnt_reg;

   // Counts symbols that actually go onto the line; a disabled load is not counted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (load_active && (cnt_reg != 16'hFFFF)) begin
         cnt_reg <= cnt_reg + 16'd1;
      end
   end

   assign tx.tx_sym_cnt = cnt_reg;
`endif

endmodule
